// File: rtl/lvdc_pkg.sv
// Shared constants and types for the accumulator delay line.
package lvdc_pkg;

  // Bits per stored word; one bit circulates per bit time.
  localparam int WORD_BITS = 26;

  // Width of the bit-position counter (covers 0..WORD_BITS-1).
  localparam int POS_BITS = 5;

  // ALIGN: waiting for a word-sync strobe; RUN: line circulating.
  typedef enum logic {
    ALIGN = 1'b0,
    RUN   = 1'b1
  } state_t;

endpackage

// File: rtl/acc_delay_line_if.sv
// Bit-serial connection between the arithmetic section (master) and the
// accumulator delay line (slave), plus the observation/load side path.
//
// Handshake: there is no valid/ready pair. bit_stb is a one-clock qualifier;
// sync_in, dl31 and dl44 are only meaningful on a clock where bit_stb is high.
// load is a one-clock command that takes priority over a coincident bit_stb.
// All outputs are registered and change only on the rising clock edge
// (or immediately on reset).
interface acc_delay_line_if
  import lvdc_pkg::*;
#(
  parameter int WIDTH = WORD_BITS
);

  logic                bit_stb;
  logic                sync_in;
  logic                dl44;
  logic                dl31;
  logic                load;
  logic [WIDTH-1:0]    load_data;

  logic                acc0;
  logic [POS_BITS-1:0] bit_pos;
  logic                word_end;
  logic                acc_zero;
  logic                acc_sign;
  logic                aligned;
  logic [WIDTH-1:0]    word;
  state_t              state;

  modport master (
    output bit_stb, sync_in, dl44, dl31, load, load_data,
    input  acc0, bit_pos, word_end, acc_zero, acc_sign, aligned, word, state
  );

  modport slave (
    input  bit_stb, sync_in, dl44, dl31, load, load_data,
    output acc0, bit_pos, word_end, acc_zero, acc_sign, aligned, word, state
  );

endinterface

// File: rtl/acc_delay_line_bit_timer.sv
// Modulo-WIDTH bit-position counter with sync-force, load-clear and a
// registered end-of-word pulse.
module bit_timer
  import lvdc_pkg::*;
#(
  parameter int WIDTH = WORD_BITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stb,       // shift strobe already gated by the FSM
  input  logic                sync,      // strobe is bit position 0
  input  logic                load,      // parallel load, resets position
  output logic [POS_BITS-1:0] pos,
  output logic                word_end,
  output logic                last,      // this strobe shifts bit WIDTH-1
  output logic                slip       // sync arrived away from position 0
);

  localparam logic [POS_BITS-1:0] LAST_POS = POS_BITS'(WIDTH - 1);

  logic [POS_BITS-1:0] eff_pos;

  // A sync strobe is always treated as position 0, whatever the counter says.
  always_comb begin
    eff_pos = sync ? '0 : pos;
    slip    = stb & sync & (pos != '0);
    last    = stb & (eff_pos == LAST_POS);
  end

  // Advance the position on each strobe and pulse word_end after the last bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos      <= '0;
      word_end <= 1'b0;
    end else if (load) begin
      pos      <= '0;
      word_end <= 1'b0;
    end else if (stb) begin
      word_end <= last;
      pos      <= (eff_pos == LAST_POS) ? '0 : eff_pos + 1'b1;
    end else begin
      word_end <= 1'b0;
    end
  end

endmodule

// File: rtl/acc_delay_line.sv
// Serial accumulator store: a WIDTH-bit recirculating shift register that
// replaces the glass delay line, with word alignment, zero/sign capture and
// a parallel load/observe path.
module acc_delay_line
  import lvdc_pkg::*;
#(
  parameter int   WIDTH     = WORD_BITS,
  parameter logic ZERO_INIT = 1'b1
) (
  input logic              clk,
  input logic              rst,
  acc_delay_line_if.slave  bus
);

  logic [WIDTH-1:0]    line;
  state_t              state;
  logic                aligned_q;
  logic                zero_q;
  logic                sign_q;
  logic                acc_q;      // OR of the bits written so far this word

  logic                run_stb;
  logic                tail;
  logic [POS_BITS-1:0] pos;
  logic                word_end;
  logic                last;
  logic                slip;

  // A strobe shifts when running, or when a sync strobe pulls ALIGN into RUN.
  // DL31 is active low: 0 writes DL44, 1 recirculates the line head.
  always_comb begin
    run_stb = bus.bit_stb & ~bus.load & ((state == RUN) | bus.sync_in);
    tail    = bus.dl31 ? line[0] : bus.dl44;
  end

  bit_timer #(
    .WIDTH (WIDTH)
  ) u_bit_timer (
    .clk      (clk),
    .rst      (rst),
    .stb      (run_stb),
    .sync     (bus.sync_in),
    .load     (bus.load),
    .pos      (pos),
    .word_end (word_end),
    .last     (last),
    .slip     (slip)
  );

  // FSM, line shift and per-word zero/sign capture; load beats a strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line      <= '0;
      state     <= ALIGN;
      aligned_q <= 1'b0;
      zero_q    <= ZERO_INIT;
      sign_q    <= 1'b0;
      acc_q     <= 1'b0;
    end else if (bus.load) begin
      line      <= bus.load_data;
      state     <= RUN;
      aligned_q <= 1'b1;
      acc_q     <= 1'b0;
      zero_q    <= (bus.load_data == '0);
      sign_q    <= bus.load_data[WIDTH-1];
    end else if (run_stb) begin
      line      <= {tail, line[WIDTH-1:1]};
      state     <= RUN;
      aligned_q <= 1'b1;
      if (last) begin
        zero_q <= ~(acc_q | tail);
        sign_q <= tail;
        acc_q  <= 1'b0;
      end else if (slip) begin
        // Realignment starts a fresh word at position 0.
        acc_q <= tail;
      end else begin
        acc_q <= acc_q | tail;
      end
    end
  end

  assign bus.acc0     = line[0];
  assign bus.bit_pos  = pos;
  assign bus.word_end = word_end;
  assign bus.acc_zero = zero_q;
  assign bus.acc_sign = sign_q;
  assign bus.aligned  = aligned_q;
  assign bus.word     = line;
  assign bus.state    = state;

endmodule
